shift_right_seq: RTL and testbench

//   Sequential right shifter (logical or arithmetic) for the ALU datapath; companion to the

---
 rtl/shift_right_seq.sv | 138 +++++++++++++
 tb/tb_shift_right_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// shift_right_seq: sequential logical/arithmetic right shifter.
// Shift amount B is applied one binary weight per clock, LSB first, so a
// result always appears exactly Nbits clocks after the operation is taken.
// LOST flags that at least one 1 bit fell off the low end during the op.
module shift_right_seq #(
  parameter int Nbits = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [Nbits-1:0] A,
  input  logic [Nbits-1:0] B,
  input  logic             ARITH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [Nbits-1:0] OUT,
  output logic             LOST
);

  // Step counter width; steps below LG shift inside the word, the rest saturate.
  localparam int SW = (Nbits > 1) ? $clog2(Nbits) : 1;
  localparam int LG = $clog2(Nbits);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [Nbits-1:0]  work_q,  work_d;
  logic [Nbits-1:0]  b_q,     b_d;
  logic              fill_q,  fill_d;
  logic              lost_q,  lost_d;
  logic [SW-1:0]     step_q,  step_d;

  logic              accept_s;
  logic [Nbits-1:0]  sel_work_s;
  logic              sel_lost_s;

  // Per-step candidate results, one per binary weight 2**k.
  logic [Nbits-1:0]  step_work_s [Nbits];
  logic [Nbits-1:0]  step_lost_s;

  // Build the candidate shift for every step weight at elaboration time.
  for (genvar k = 0; k < Nbits; k++) begin : g_step
    if (k < LG) begin : g_in_range
      localparam int SH = 1 << k;
      assign step_work_s[k] = (work_q >> SH) | ({Nbits{fill_q}} << (Nbits - SH));
      assign step_lost_s[k] = |(work_q & ({Nbits{1'b1}} >> (Nbits - SH)));
    end else begin : g_saturate
      // 2**k >= Nbits: every bit of the work word leaves, fill takes over.
      assign step_work_s[k] = {Nbits{fill_q}};
      assign step_lost_s[k] = |work_q;
    end
  end

  assign IN_READY  = (state_q == IDLE) | ((state_q == HOLD) & OUT_READY);
  assign OUT_VALID = (state_q == HOLD);
  assign OUT       = work_q;
  assign LOST      = lost_q;
  assign accept_s  = IN_VALID & IN_READY;

  // Pick the candidate for the current step, or pass through when B[step] is 0.
  always_comb begin
    sel_work_s = work_q;
    sel_lost_s = 1'b0;
    for (int k = 0; k < Nbits; k++) begin
      sel_work_s = ((step_q == SW'(k)) && b_q[k]) ? step_work_s[k] : sel_work_s;
      sel_lost_s = ((step_q == SW'(k)) && b_q[k]) ? step_lost_s[k] : sel_lost_s;
    end
  end

  // Next-state and datapath update: accept, step through B, hold the result.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    b_d     = b_q;
    fill_d  = fill_q;
    lost_d  = lost_q;
    step_d  = step_q;
    if (accept_s) begin
      // Only reachable from IDLE or from HOLD while the result is being taken.
      work_d  = A;
      b_d     = B;
      fill_d  = ARITH & A[Nbits-1];
      lost_d  = 1'b0;
      step_d  = '0;
      state_d = SHIFT;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          work_d = sel_work_s;
          lost_d = lost_q | sel_lost_s;
          if (step_q == SW'(Nbits - 1)) begin
            state_d = HOLD;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      work_q  <= '0;
      b_q     <= '0;
      fill_q  <= 1'b0;
      lost_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      b_q     <= b_d;
      fill_q  <= fill_d;
      lost_q  <= lost_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Testbench for shift_right_seq: directed cases and randomized traffic on a
// 4-bit and an 8-bit instance, checked through a queue-based scoreboard.
module tb_shift_right_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv4, ir4, ar4, ov4, or4, lost4;
  logic [3:0] a4, b4, out4;
  logic       iv8, ir8, ar8, ov8, or8, lost8;
  logic [7:0] a8, b8, out8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic rnd_rdy4 = 1'b0;
  logic rnd_rdy8 = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        lost;
    int          acc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t cur4, cur8;
  logic hold4, hold8;

  shift_right_seq #(.Nbits(4)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(iv4), .IN_READY(ir4), .A(a4), .B(b4),
    .ARITH(ar4), .OUT_VALID(ov4), .OUT_READY(or4), .OUT(out4), .LOST(lost4)
  );

  shift_right_seq #(.Nbits(8)) u_dut8 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(iv8), .IN_READY(ir8), .A(a8), .B(b8),
    .ARITH(ar8), .OUT_VALID(ov8), .OUT_READY(or8), .OUT(out8), .LOST(lost8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: view A as extended by its fill bit (sign or zero) forever to the
  // left; the result is the window starting at bit B, LOST is OR of bits [B-1:0].
  function automatic void model(input int n, input logic [31:0] a, input int b,
                                input logic ar, output logic [31:0] res, output logic lost);
    logic fill;
    fill = ar & a[n-1];
    res  = '0;
    lost = 1'b0;
    for (int i = 0; i < n; i++) res[i] = (i + b < n) ? a[i + b] : fill;
    for (int i = 0; i < b; i++) lost = lost | ((i < n) ? a[i] : fill);
  endfunction

  // Cycle counter for latency measurement.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready generators for the random phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy4) or4 = ($urandom_range(0, 3) != 0);
    if (rnd_rdy8) or8 = ($urandom_range(0, 2) != 0);
  end

  // Stimulus side of the scoreboard: push expected result on every accept.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && iv4 && ir4) begin
      model(4, {28'd0, a4}, int'(b4), ar4, e.res, e.lost);
      e.acc = cyc + 1;
      q4.push_back(e);
    end
    if (rst_n && iv8 && ir8) begin
      model(8, {24'd0, a8}, int'(b8), ar8, e.res, e.lost);
      e.acc = cyc + 1;
      q8.push_back(e);
    end
  end

  // Monitor for the 4-bit instance.
  initial begin
    hold4 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold4 = 1'b0;
      end else if (ov4) begin
        if (!hold4) begin
          if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected4 actual=result_valid required=no_pending_op");
          end else begin
            cur4 = q4.pop_front();
            chk("latency4", 64'(cyc - cur4.acc), 64'd4);
          end
          hold4 = 1'b1;
        end
        chk("out4", {60'd0, out4}, {60'd0, cur4.res[3:0]});
        chk("lost4", {63'd0, lost4}, {63'd0, cur4.lost});
        if (or4) hold4 = 1'b0;
      end
    end
  end

  // Monitor for the 8-bit instance.
  initial begin
    hold8 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold8 = 1'b0;
      end else if (ov8) begin
        if (!hold8) begin
          if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected8 actual=result_valid required=no_pending_op");
          end else begin
            cur8 = q8.pop_front();
            chk("latency8", 64'(cyc - cur8.acc), 64'd8);
          end
          hold8 = 1'b1;
        end
        chk("out8", {56'd0, out8}, {56'd0, cur8.res[7:0]});
        chk("lost8", {63'd0, lost8}, {63'd0, cur8.lost});
        if (or8) hold8 = 1'b0;
      end
    end
  end

  // Offer one op to the 4-bit instance until taken; entered and left at posedge+1.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic ar);
    int w;
    iv4 = 1'b1; a4 = a; b4 = b; ar4 = ar;
    w = 0;
    @(negedge clk);
    while (!ir4 && w < 200) begin
      w++;
      @(negedge clk);
    end
    chk("send4_ready", {63'd0, ir4}, 64'd1);
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); ar4 = 1'($urandom);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ar);
    int w;
    iv8 = 1'b1; a8 = a; b8 = b; ar8 = ar;
    w = 0;
    @(negedge clk);
    while (!ir8 && w < 200) begin
      w++;
      @(negedge clk);
    end
    chk("send8_ready", {63'd0, ir8}, 64'd1);
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); ar8 = 1'($urandom);
  endtask

  // Wait (bounded) until the 4-bit result is presented; leaves at a negedge.
  task automatic wait4();
    int w;
    w = 0;
    @(negedge clk);
    while (!ov4 && w < 100) begin
      w++;
      @(negedge clk);
    end
    chk("wait4_valid", {63'd0, ov4}, 64'd1);
  endtask

  // Directed op on the 4-bit instance with literal expected result.
  task automatic dir4(input string nm, input logic [3:0] a, input logic [3:0] b,
                      input logic ar, input logic [3:0] eo, input logic el);
    send4(a, b, ar);
    wait4();
    chk({nm, "_out"}, {60'd0, out4}, {60'd0, eo});
    chk({nm, "_lost"}, {63'd0, lost4}, {63'd0, el});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0;
    iv4 = 1'b0; a4 = 4'd0; b4 = 4'd0; ar4 = 1'b0; or4 = 1'b1;
    iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; ar8 = 1'b0; or8 = 1'b1;
    #2;
    chk("rst_out_valid", {63'd0, ov4}, 64'd0);
    chk("rst_out", {60'd0, out4}, 64'd0);
    chk("rst_lost", {63'd0, lost4}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, ir4}, 64'd1);
    @(posedge clk);
    #1;

    dir4("logic_1011_1",  4'b1011, 4'b0001, 1'b0, 4'b0101, 1'b1);
    dir4("arith_1000_2",  4'b1000, 4'b0010, 1'b1, 4'b1110, 1'b0);
    dir4("arith_1001_15", 4'b1001, 4'b1111, 1'b1, 4'b1111, 1'b1);
    dir4("sat_1111_4",    4'b1111, 4'b0100, 1'b0, 4'b0000, 1'b1);
    dir4("zero_0110_0",   4'b0110, 4'b0000, 1'b0, 4'b0110, 1'b0);

    // Back-pressure, then a back-to-back accept on the releasing edge.
    or4 = 1'b0;
    send4(4'b0011, 4'b0001, 1'b0);
    wait4();
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, ir4}, 64'd0);
      chk("bp_out", {60'd0, out4}, 64'd1);
      chk("bp_lost", {63'd0, lost4}, 64'd1);
    end
    @(posedge clk);
    #1;
    iv4 = 1'b1; a4 = 4'b0100; b4 = 4'b0001; ar4 = 1'b0; or4 = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", {63'd0, ir4}, 64'd1);
    @(posedge clk);
    #1;
    iv4 = 1'b0; a4 = 4'b1111; b4 = 4'b0000;
    wait4();
    chk("b2b_out", {60'd0, out4}, 64'd2);
    chk("b2b_lost", {63'd0, lost4}, 64'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of an operation.
    send4(4'b1011, 4'b0011, 1'b1);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, ov4}, 64'd0);
    chk("midrst_out", {60'd0, out4}, 64'd0);
    chk("midrst_lost", {63'd0, lost4}, 64'd0);
    q4.delete();
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", {63'd0, ir4}, 64'd1);
    idle(8);
    chk("midrst_no_stale", {63'd0, ov4}, 64'd0);

    // Random traffic on both widths with random consumer stalls.
    rnd_rdy4 = 1'b1;
    rnd_rdy8 = 1'b1;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          send4(4'($urandom), 4'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end
      end
      begin
        for (int j = 0; j < 600; j++) begin
          if ($urandom_range(0, 1) == 0) send8(8'($urandom), 8'($urandom_range(0, 10)), 1'($urandom));
          else send8(8'($urandom), 8'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end
      end
    join
    rnd_rdy4 = 1'b0;
    rnd_rdy8 = 1'b0;
    #1;
    or4 = 1'b1;
    or8 = 1'b1;
    w = 0;
    while ((q4.size() != 0 || q8.size() != 0 || ov4 || ov8) && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain4", 64'(q4.size()), 64'd0);
    chk("drain8", 64'(q8.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
